rsa_modexp_ctrl: RTL and testbench

//  Sequencer for RSA modular exponentiation: result = base^exponent mod modulus.

---
 rtl/rsa_modexp_ctrl_if.sv | 28 ++
 rtl/rsa_modexp_ctrl.sv | 162 ++++++++++++++++
 tb/tb_rsa_modexp_ctrl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/rsa_modexp_ctrl_if.sv
// Bus between the modexp sequencer, its requester and the external divider.
// The master side drives requests and the divider remainder; the slave is the sequencer.
interface rsa_modexp_ctrl_if #(
   parameter int WIDTH = 16,
   parameter int DW    = 32
);
   logic             start;
   logic [WIDTH-1:0] base;
   logic [WIDTH-1:0] exponent;
   logic [WIDTH-1:0] modulus;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             err;
   logic [DW-1:0]    div_a;
   logic [DW-1:0]    div_b;
   logic [DW-1:0]    div_rem;

   modport master (
      output start, base, exponent, modulus, div_rem,
      input  busy, done, result, err, div_a, div_b
   );

   modport slave (
      input  start, base, exponent, modulus, div_rem,
      output busy, done, result, err, div_a, div_b
   );
endinterface

// File: rtl/rsa_modexp_ctrl.sv
// Right-to-left square-and-multiply modexp sequencer.
// All reductions go through one external combinational divider.
module rsa_modexp_ctrl #(
   parameter int WIDTH    = 16,
   parameter int DW       = 32,
   parameter int DIV_WAIT = 0
) (
   input logic               clk,
   input logic               rst,
   rsa_modexp_ctrl_if.slave  bus
);
   typedef enum logic [2:0] {
      S_IDLE,
      S_REDUCE,
      S_MUL,
      S_SQR,
      S_FIN
   } state_t;

   localparam int KW = $clog2(WIDTH + 1);
   localparam int CW = (DIV_WAIT > 0) ? $clog2(DIV_WAIT + 1) : 1;

   state_t           state_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;
   logic [WIDTH-1:0] result_q;
   logic [WIDTH-1:0] r_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH-1:0] e_q;
   logic [WIDTH-1:0] mod_q;
   logic [KW-1:0]    k_q;
   logic [CW-1:0]    cnt_q;
   logic [DW-1:0]    div_a_q;
   logic [DW-1:0]    div_b_q;

   logic [WIDTH-1:0] rem_w;
   logic [DW-1:0]    mul_d;
   logic [DW-1:0]    sqr_d;
   logic [DW-1:0]    bsq_d;
   logic [WIDTH-1:0] e_d;
   logic             op_end;
   logic             unused_rem;

   // Remainder is always below the modulus, so only the low half matters.
   assign rem_w      = bus.div_rem[WIDTH-1:0];
   assign unused_rem = ^bus.div_rem[DW-1:WIDTH];
   assign mul_d      = DW'(r_q) * DW'(rem_w);
   assign sqr_d      = DW'(rem_w) * DW'(rem_w);
   assign bsq_d      = DW'(b_q) * DW'(b_q);
   assign e_d        = e_q >> 1;
   assign op_end     = (cnt_q == CW'(DIV_WAIT));

   assign bus.busy   = busy_q;
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.err    = err_q;
   assign bus.div_a  = div_a_q;
   assign bus.div_b  = div_b_q;

   // Sequencer: each divider state dwells until op_end, then captures the
   // remainder and registers the next dividend on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
         r_q      <= '0;
         b_q      <= '0;
         e_q      <= '0;
         mod_q    <= '0;
         k_q      <= '0;
         cnt_q    <= '0;
         div_a_q  <= '0;
         div_b_q  <= '0;
      end else begin
         unique case (state_q)
            S_IDLE: begin
               if (bus.start) begin
                  busy_q   <= 1'b1;
                  result_q <= '0;
                  err_q    <= (bus.modulus == '0);
                  mod_q    <= bus.modulus;
                  cnt_q    <= '0;
                  if (bus.modulus == '0) begin
                     state_q <= S_FIN;
                  end else begin
                     r_q     <= WIDTH'(1);
                     e_q     <= bus.exponent;
                     k_q     <= '0;
                     div_a_q <= DW'(bus.base);
                     div_b_q <= DW'(bus.modulus);
                     state_q <= S_REDUCE;
                  end
               end
            end
            S_REDUCE: begin
               if (!op_end) begin
                  cnt_q <= cnt_q + 1'b1;
               end else begin
                  cnt_q <= '0;
                  b_q   <= rem_w;
                  if (e_q[0]) begin
                     div_a_q <= mul_d;
                     state_q <= S_MUL;
                  end else begin
                     div_a_q <= sqr_d;
                     state_q <= S_SQR;
                  end
               end
            end
            S_MUL: begin
               if (!op_end) begin
                  cnt_q <= cnt_q + 1'b1;
               end else begin
                  cnt_q   <= '0;
                  r_q     <= rem_w;
                  div_a_q <= bsq_d;
                  state_q <= S_SQR;
               end
            end
            S_SQR: begin
               if (!op_end) begin
                  cnt_q <= cnt_q + 1'b1;
               end else begin
                  cnt_q <= '0;
                  b_q   <= rem_w;
                  e_q   <= e_d;
                  k_q   <= k_q + 1'b1;
                  if (k_q == KW'(WIDTH - 1)) begin
                     done_q   <= 1'b1;
                     result_q <= (mod_q == WIDTH'(1)) ? '0 : r_q;
                     state_q  <= S_FIN;
                  end else if (e_d[0]) begin
                     div_a_q <= mul_d;
                     state_q <= S_MUL;
                  end else begin
                     div_a_q <= sqr_d;
                     state_q <= S_SQR;
                  end
               end
            end
            S_FIN: begin
               // Zero-modulus requests arrive here without done and spend
               // one cycle raising it; the normal path arrives with done set.
               if (!done_q) begin
                  done_q <= 1'b1;
               end else begin
                  done_q  <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_rsa_modexp_ctrl.sv
// Bench for rsa_modexp_ctrl: directed cases plus a random sweep
// against an arithmetic modexp model, with a behavioural divider.
module tb_rsa_modexp_ctrl;
   localparam int W  = 16;
   localparam int DW = 32;

   logic clk = 1'b0;
   logic rst;
   int   n_assert = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   rsa_modexp_ctrl_if #(.WIDTH(W), .DW(DW)) if0 ();
   rsa_modexp_ctrl_if #(.WIDTH(W), .DW(DW)) if2 ();

   assign if0.div_rem = (if0.div_b == '0) ? '0 : if0.div_a % if0.div_b;
   assign if2.div_rem = (if2.div_b == '0) ? '0 : if2.div_a % if2.div_b;

   rsa_modexp_ctrl #(.WIDTH(W), .DW(DW), .DIV_WAIT(0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (if0.slave)
   );

   rsa_modexp_ctrl #(.WIDTH(W), .DW(DW), .DIV_WAIT(2)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (if2.slave)
   );

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] b,
                                                input logic [W-1:0] e,
                                                input logic [W-1:0] m);
      longint unsigned r;
      longint unsigned x;
      if (m == 0 || m == 1) return '0;
      r = 1;
      x = longint'(b) % longint'(m);
      for (int i = 0; i < W; i++) begin
         if (e[i]) r = (r * x) % longint'(m);
         x = (x * x) % longint'(m);
      end
      return W'(r);
   endfunction

   task automatic drive(input bit sel, input logic st, input logic [W-1:0] b,
                        input logic [W-1:0] e, input logic [W-1:0] m);
      if (sel) begin
         if2.start = st; if2.base = b; if2.exponent = e; if2.modulus = m;
      end else begin
         if0.start = st; if0.base = b; if0.exponent = e; if0.modulus = m;
      end
   endtask

   task automatic set_start(input bit sel, input logic st);
      if (sel) if2.start = st;
      else     if0.start = st;
   endtask

   task automatic sample(input bit sel, output logic bsy, output logic dn,
                         output logic [W-1:0] res, output logic er,
                         output logic [DW-1:0] da, output logic [DW-1:0] db);
      bsy = sel ? if2.busy   : if0.busy;
      dn  = sel ? if2.done   : if0.done;
      res = sel ? if2.result : if0.result;
      er  = sel ? if2.err    : if0.err;
      da  = sel ? if2.div_a  : if0.div_a;
      db  = sel ? if2.div_b  : if0.div_b;
   endtask

   task automatic do_op(input bit sel, input logic [W-1:0] b,
                        input logic [W-1:0] e, input logic [W-1:0] m,
                        input int pulse_at, input int rst_at,
                        input string tag);
      int lat, cyc, dones;
      bit seen;
      logic bsy, dn, er;
      logic [W-1:0] res;
      logic [DW-1:0] da, db, a0, b0;
      lat = (m == 0) ? 1 : (1 + W + $countones(e)) * (sel ? 3 : 1);
      @(negedge clk);
      sample(sel, bsy, dn, res, er, a0, b0);
      drive(sel, 1'b1, b, e, m);
      @(posedge clk);
      #1;
      set_start(sel, 1'b0);
      sample(sel, bsy, dn, res, er, da, db);
      check({tag, ".busy_after_accept"}, 64'(bsy), 64'd1);
      cyc  = 0;
      seen = 0;
      while (!seen && cyc < 400) begin
         @(posedge clk);
         cyc++;
         #1;
         if (cyc == rst_at) begin
            rst = 1'b1;
            #1;
            sample(sel, bsy, dn, res, er, da, db);
            check({tag, ".rst_busy"},   64'(bsy), 64'd0);
            check({tag, ".rst_done"},   64'(dn),  64'd0);
            check({tag, ".rst_result"}, 64'(res), 64'd0);
            check({tag, ".rst_div_a"},  64'(da),  64'd0);
            rst = 1'b0;
            return;
         end
         set_start(sel, cyc == pulse_at);
         sample(sel, bsy, dn, res, er, da, db);
         if (dn) seen = 1;
      end
      set_start(sel, 1'b0);
      check({tag, ".done_seen"}, 64'(seen), 64'd1);
      check({tag, ".latency"},   64'(cyc),  64'(lat));
      check({tag, ".result"},    64'(res),  64'(ref_modexp(b, e, m)));
      check({tag, ".err"},       64'(er),   64'(m == 0));
      if (m == 0) begin
         check({tag, ".div_a_held"}, 64'(da), 64'(a0));
         check({tag, ".div_b_held"}, 64'(db), 64'(b0));
      end
      dones = 0;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         sample(sel, bsy, dn, res, er, da, db);
         if (dn) dones++;
      end
      check({tag, ".extra_done"}, 64'(dones), 64'd0);
      check({tag, ".idle_busy"},  64'(bsy),   64'd0);
   endtask

   initial begin
      logic bsy, dn, er;
      logic [W-1:0] res;
      logic [DW-1:0] da, db;
      logic [W-1:0] rb, re, rm;
      bit sel;
      rst = 1'b1;
      drive(1'b0, 1'b0, '0, '0, '0);
      drive(1'b1, 1'b0, '0, '0, '0);
      repeat (2) @(posedge clk);
      #1;
      for (int s = 0; s < 2; s++) begin
         sample(s[0], bsy, dn, res, er, da, db);
         check("reset.busy",   64'(bsy), 64'd0);
         check("reset.done",   64'(dn),  64'd0);
         check("reset.result", 64'(res), 64'd0);
         check("reset.err",    64'(er),  64'd0);
         check("reset.div_a",  64'(da),  64'd0);
         check("reset.div_b",  64'(db),  64'd0);
      end
      @(negedge clk);
      rst = 1'b0;

      do_op(1'b0, 16'd4, 16'd13, 16'd497, -1, -1, "c1");
      do_op(1'b0, 16'd3, 16'd0, 16'd7, -1, -1, "c2");
      do_op(1'b0, 16'd65534, 16'd65535, 16'd65535, -1, -1, "c3");
      do_op(1'b0, 16'd1234, 16'd77, 16'd1, -1, -1, "c4_mod1");
      do_op(1'b0, 16'd9, 16'd9, 16'd0, -1, -1, "c4_mod0");
      do_op(1'b0, 16'd4, 16'd13, 16'd497, 5, -1, "c5_restart_ignored");
      do_op(1'b0, 16'd4, 16'd13, 16'd497, -1, 8, "c6_reset");
      do_op(1'b0, 16'd4, 16'd13, 16'd497, -1, -1, "c6_after_reset");
      do_op(1'b1, 16'd4, 16'd13, 16'd497, -1, -1, "c1_wait2");

      for (int i = 0; i < 25; i++) begin
         sel = ($urandom_range(0, 3) == 0);
         rb  = W'($urandom);
         re  = W'($urandom);
         case ($urandom_range(0, 7))
            0:       rm = 16'd0;
            1:       rm = 16'd1;
            default: rm = W'($urandom);
         endcase
         do_op(sel, rb, re, rm, -1, -1, $sformatf("rand%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end
endmodule
